pixel_readout_collector: RTL and testbench
==========================================

PIXEL_READOUT_COLLECTOR -- requirements
Module: pixel_readout_collector

Interface
REQ-001 Parameter N_COL, default 4: number of column slots per readout, equal to the select token width.
REQ-002 Parameter DATA_W, default 8: pixel sample width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle request to begin a row readout.
REQ-006 read  output  1  one-cycle pulse that loads the one-hot select token in the column shift register.
REQ-007 sel_in  input  N_COL  one-hot select token returned from the column shift register, MSB first.
REQ-008 pix_data  input  DATA_W  analog-front-end sample for the currently selected column.
REQ-009 out_data  output  DATA_W  buffered pixel value presented to the consumer.
REQ-010 out_col  output  clog2(N_COL)  column index of out_data; 0 means the column selected first (token MSB).
REQ-011 out_valid  output  1  out_data and out_col are valid.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky token-mismatch flag.

Function
REQ-015 The FSM SHALL have the states IDLE, ARM, SCAN and DRAIN.
REQ-016 IDLE: start=1 SHALL move the FSM to ARM and clear err; start SHALL be ignored in every other state.
REQ-017 ARM: read SHALL be 1 for exactly this one cycle, and the FSM SHALL move to SCAN on the next cycle.
REQ-018 SCAN SHALL last exactly N_COL cycles; on scan cycle k (k=0..N_COL-1), pix_data SHALL be written to buffer entry k.
REQ-019 On scan cycle k, sel_in SHALL equal a one-hot vector with bit N_COL-1-k set; any other value SHALL set err (sticky), and the sample SHALL still be stored.
REQ-020 After scan cycle N_COL-1, the FSM SHALL move to DRAIN with its read pointer at 0.
REQ-021 DRAIN: out_valid SHALL be 1, with out_data = buffer[ptr] and out_col = ptr.
REQ-022 DRAIN: on a handshake the pointer SHALL increment; the handshake at ptr=N_COL-1 SHALL return the FSM to IDLE with out_valid=0 on the next cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_col SHALL hold stable.
REQ-024 Latency from start to the first out_valid SHALL be N_COL+2 cycles: one cycle into ARM, one cycle into SCAN, then N_COL scan cycles.
REQ-025 out_valid SHALL be 0 in IDLE, ARM and SCAN.
REQ-026 start asserted in the same cycle as the final DRAIN handshake SHALL be ignored; the FSM SHALL still enter IDLE.
REQ-027 The buffer SHALL be N_COL x DATA_W, written only in SCAN and read only in DRAIN.
REQ-028 The pointer SHALL count 0..N_COL-1 and never wrap within one readout.

Reset
REQ-029 reset=0 SHALL immediately force: state IDLE, read=0, out_valid=0, busy=0, err=0, out_data=0, out_col=0, pointer=0.
REQ-030 Reset asserted mid-SCAN or mid-DRAIN SHALL abandon the readout; the buffer contents need not be cleared.
REQ-031 After reset release, the block SHALL wait in IDLE for start.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default N_COL and DATA_W constants.
REQ-033 One sub-module, readout_buffer, SHALL hold the N_COL-entry register file with a write port (index, data, enable) and a combinational read port.
REQ-034 The FSM, pointer, token checker and err flag SHALL reside in pixel_readout_collector.

Verification
REQ-035 Nominal readout: start; bench model drives sel_in 1000,0100,0010,0001 and pix_data 0x11,0x22,0x33,0x44; out_ready=1 -> read pulses 1 cycle after start; out_valid first at start+6; words (0,0x11),(1,0x22),(2,0x33),(3,0x44); err=0.
REQ-036 Backpressure: as REQ-035 with out_ready low for 3 cycles at each word -> each word held stable, no word lost or duplicated, FSM returns to IDLE after the 4th handshake.
REQ-037 Token fault: sel_in=0100 on scan cycle 0 -> err=1 through DRAIN and IDLE; err=0 after the next start.
REQ-038 start while busy: pulse start during SCAN and during DRAIN -> no extra read pulse, output sequence unchanged.
REQ-039 Reset mid-operation: reset=0 on scan cycle 2 -> outputs at reset values immediately; the next start yields a clean 4-word readout.
REQ-040 Simultaneous end and start: start asserted with the final handshake -> IDLE, no read pulse; a later start works normally.

Source files
------------

// File: rtl/pixel_readout_collector_pkg.sv
// Shared types and default sizing for the pixel row readout collector.
package pixel_readout_collector_pkg;
  typedef enum logic [1:0] {IDLE, ARM, SCAN, DRAIN} state_t;

  localparam int N_COL_DEF  = 4;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/pixel_readout_collector_buffer.sv
// Row sample buffer: one registered write port, one combinational read port.
module readout_buffer #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [N-1:0][W-1:0] mem;

  // Contents survive reset; an abandoned row is simply overwritten next scan.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_readout_collector.sv
// Row readout sequencer: arms the column token, captures one sample per
// column while checking the token, then drains the row over valid/ready.
module pixel_readout_collector
  import pixel_readout_collector_pkg::*;
#(
  parameter int N_COL  = N_COL_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 read,
  input  logic [N_COL-1:0]                     sel_in,
  input  logic [DATA_W-1:0]                    pix_data,
  output logic [DATA_W-1:0]                    out_data,
  output logic [(N_COL>1?$clog2(N_COL):1)-1:0] out_col,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 err
);
  localparam int              PW   = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam logic [PW-1:0]   LAST = PW'(N_COL - 1);
  localparam logic [N_COL-1:0] TOK0 = {1'b1, {(N_COL-1){1'b0}}};

  state_t             state, state_nx;
  logic [PW-1:0]      ptr, ptr_nx;
  logic               err_nx;
  logic [N_COL-1:0]   tok_exp;
  logic [DATA_W-1:0]  rdata;

  // The token walks from MSB to LSB in lockstep with the scan index.
  assign tok_exp = TOK0 >> ptr;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      err   <= err_nx;
    end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    err_nx   = err;
    case (state)
      IDLE:
        if (start) begin
          state_nx = ARM;
          err_nx   = 1'b0;
        end
      ARM: begin
        state_nx = SCAN;
        ptr_nx   = '0;
      end
      SCAN: begin
        if (sel_in != tok_exp) err_nx = 1'b1;
        if (ptr == LAST) begin
          state_nx = DRAIN;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      DRAIN:
        if (out_ready) begin
          if (ptr == LAST) begin
            state_nx = IDLE;
            ptr_nx   = '0;
          end else begin
            ptr_nx = ptr + 1'b1;
          end
        end
      default: state_nx = IDLE;
    endcase
  end

  readout_buffer #(.N(N_COL), .W(DATA_W), .AW(PW)) u_buf (
    .clk   (clk),
    .we    (state == SCAN),
    .waddr (ptr),
    .wdata (pix_data),
    .raddr (ptr),
    .rdata (rdata)
  );

  assign read      = (state == ARM);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? rdata : '0;
  assign out_col   = out_valid ? ptr : '0;
endmodule

// File: tb/tb_pixel_readout_collector.sv
// Randomized bench: driver pushes expected words and point checks into queues,
// a negedge monitor pops and compares them against the DUT.
module tb_pixel_readout_collector;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] sel_in = '0;
  logic [7:0] pix_data = '0;
  logic       read, out_valid, busy, err;
  logic [7:0] out_data;
  logic [1:0] out_col;

  pixel_readout_collector dut (
    .clk(clk), .reset(reset), .start(start), .read(read), .sel_in(sel_in),
    .pix_data(pix_data), .out_data(out_data), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] col; logic [7:0] data; } word_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

  word_t sb[$];
  chk_t  cq[$];
  int    checks = 0;
  int    errors = 0;
  int    read_cnt = 0;
  bit    hold = 1'b0;
  logic [7:0] hd;
  logic [1:0] hc;

  task automatic expect_eq(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n; c.act = a; c.exp = e;
    cq.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sole owner of the check/error counters.
  always @(negedge clk) begin
    chk_t  c;
    word_t w;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
      end
    end
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (read) read_cnt++;
      if (hold) begin
        checks++;
        if (!out_valid || out_data !== hd || out_col !== hc) begin
          errors++;
          $display("FAIL hold: got v=%0b col=%0d data=%0h expected v=1 col=%0d data=%0h",
                   out_valid, out_col, out_data, hc, hd);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL word: got col=%0d data=%0h expected no word", out_col, out_data);
        end else begin
          w = sb.pop_front();
          if (out_col !== w.col || out_data !== w.data) begin
            errors++;
            $display("FAIL word: got col=%0d data=%0h expected col=%0d data=%0h",
                     out_col, out_data, w.col, w.data);
          end
        end
      end
      hold = out_valid && !out_ready;
      hd   = out_data;
      hc   = out_col;
    end
  end

  // One full row readout. fault_k selects the scan cycle whose token is
  // corrupted by XOR with fxor (fault_k outside 0..3 means no fault).
  task automatic readout(input int fault_k, input logic [3:0] fxor, input bit fixed,
                         input int bp_min, input int bp_max,
                         input bit busy_start, input bit end_start);
    logic [7:0] d;
    logic [3:0] tok;
    word_t      w;
    int         rc0, bp;
    bit         exp_err;
    exp_err = 1'b0;
    rc0 = read_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_eq("arm_read", read, 1);
    expect_eq("arm_busy", busy, 1);
    expect_eq("arm_err_clr", err, 0);
    expect_eq("arm_valid", out_valid, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      d   = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
      tok = 4'b1000 >> k;
      if (k == fault_k) begin
        tok = tok ^ fxor;
        exp_err = 1'b1;
      end
      sel_in = tok;
      pix_data = d;
      w.col = 2'(k);
      w.data = d;
      sb.push_back(w);
      if (busy_start && k == 1) start = 1'b1;
      expect_eq("scan_valid", out_valid, 0);
      expect_eq("scan_read", read, 0);
      cyc();
      start = 1'b0;
    end
    sel_in = '0;
    expect_eq("latency_valid", out_valid, 1);
    expect_eq("err_drain", err, exp_err);
    for (int n = 0; n < 4; n++) begin
      bp = $urandom_range(bp_max, bp_min);
      out_ready = 1'b0;
      repeat (bp) cyc();
      out_ready = 1'b1;
      if (busy_start && n == 1) start = 1'b1;
      if (end_start && n == 3) start = 1'b1;
      cyc();
      start = 1'b0;
      out_ready = 1'b0;
    end
    expect_eq("end_valid", out_valid, 0);
    expect_eq("end_busy", busy, 0);
    expect_eq("err_idle", err, exp_err);
    cyc();
    cyc();
    expect_eq("read_once", read_cnt - rc0, 1);
    expect_eq("sb_empty", sb.size(), 0);
    expect_eq("idle_busy", busy, 0);
  endtask

  initial begin
    #12;
    expect_eq("rst_valid", out_valid, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_read", read, 0);
    expect_eq("rst_err", err, 0);
    expect_eq("rst_data", out_data, 0);
    expect_eq("rst_col", out_col, 0);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    expect_eq("idle_wait", busy, 0);

    // nominal, backpressure, token fault then recovery, start while busy
    readout(-1, 4'h0, 1'b1, 0, 0, 1'b0, 1'b0);
    readout(-1, 4'h0, 1'b1, 3, 3, 1'b0, 1'b0);
    readout(0, 4'b1100, 1'b1, 0, 0, 1'b0, 1'b0);
    readout(-1, 4'h0, 1'b1, 0, 1, 1'b0, 1'b0);
    readout(-1, 4'h0, 1'b0, 0, 2, 1'b1, 1'b0);

    // reset during scan cycle 2 after a token fault
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      sel_in = (k == 0) ? 4'b0100 : 4'b0100;
      pix_data = 8'($urandom);
      cyc();
    end
    expect_eq("pre_rst_err", err, 1);
    #2;
    reset = 1'b0;
    #1;
    expect_eq("mid_rst_busy", busy, 0);
    expect_eq("mid_rst_valid", out_valid, 0);
    expect_eq("mid_rst_read", read, 0);
    expect_eq("mid_rst_err", err, 0);
    expect_eq("mid_rst_data", out_data, 0);
    expect_eq("mid_rst_col", out_col, 0);
    sel_in = '0;
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    expect_eq("post_rst_idle", busy, 0);
    readout(-1, 4'h0, 1'b1, 0, 0, 1'b0, 1'b0);

    // start coinciding with the final handshake, then a normal readout
    readout(-1, 4'h0, 1'b0, 0, 1, 1'b0, 1'b1);
    readout(-1, 4'h0, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      readout($urandom_range(7, 0), 4'($urandom_range(15, 1)), 1'b0, 0, 3,
              1'($urandom), 1'($urandom));

    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
